boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: clears program/data memories, then streams a header-framed
// image into them while holding the core in reset, and finally releases it.
//
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   start               - level-sampled load request (honoured in IDLE/DONE)
//   in_valid/in_ready   - image stream handshake, in_data beat, in_last ends image
//   prog_we/addr/wdata  - program memory write port (1-cycle registered)
//   data_we/addr/wdata  - data memory write port (1-cycle registered)
//   core_reset          - active-low reset to the core, high only in DONE
//   busy, done, error   - status; error is sticky until the next CLEAR
module boot_loader #(
    parameter int                    WORD_WIDTH    = 32,
    parameter int                    PROG_DEPTH    = 256,
    parameter int                    DATA_DEPTH    = 256,
    parameter logic [WORD_WIDTH-1:0] PROG_FILL     = '0,
    parameter logic [WORD_WIDTH-1:0] DATA_FILL     = '0,
    parameter int                    RELEASE_DELAY = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_WIDTH-1:0]         in_data,
    input  logic                          in_last,
    output logic                          prog_we,
    output logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    output logic [WORD_WIDTH-1:0]         prog_wdata,
    output logic                          data_we,
    output logic [$clog2(DATA_DEPTH)-1:0] data_addr,
    output logic [WORD_WIDTH-1:0]         data_wdata,
    output logic                          core_reset,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int PA   = $clog2(PROG_DEPTH);
    localparam int DA   = $clog2(DATA_DEPTH);
    localparam int MAXD = (PROG_DEPTH > DATA_DEPTH) ? PROG_DEPTH : DATA_DEPTH;

    localparam logic [31:0] CLR_LAST = 32'(MAXD - 1);
    localparam logic [31:0] REL_LAST = 32'(RELEASE_DELAY - 1);
    localparam logic [31:0] P_CLR    = 32'(PROG_DEPTH);
    localparam logic [31:0] D_CLR    = 32'(DATA_DEPTH);
    // base (16b) + offset (15b) never exceeds 17 bits
    localparam logic [16:0] P_LIM    = 17'(PROG_DEPTH);
    localparam logic [16:0] D_LIM    = 17'(DATA_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HEADER,
        PAYLOAD,
        RELEASE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             clr_q, clr_d;
    logic [31:0]             rel_q, rel_d;
    logic                    tgt_q, tgt_d;
    logic [16:0]             ptr_q, ptr_d;
    logic [14:0]             rem_q, rem_d;
    logic                    err_q, err_d;
    logic                    crst_q, crst_d;
    logic                    p_we_q, p_we_d;
    logic [PA-1:0]           p_addr_q, p_addr_d;
    logic [WORD_WIDTH-1:0]   p_wdata_q, p_wdata_d;
    logic                    d_we_q, d_we_d;
    logic [DA-1:0]           d_addr_q, d_addr_d;
    logic [WORD_WIDTH-1:0]   d_wdata_q, d_wdata_d;

    logic                    rdy;
    logic                    accept;
    logic                    hdr_tgt;
    logic [14:0]             hdr_cnt;
    logic [15:0]             hdr_base;

    assign rdy      = (state_q == HEADER) || (state_q == PAYLOAD);
    assign accept   = rdy && in_valid;
    assign hdr_tgt  = in_data[WORD_WIDTH-1];
    assign hdr_cnt  = in_data[30:16];
    assign hdr_base = in_data[15:0];

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        rel_d     = '0;
        tgt_d     = tgt_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        err_d     = err_q;
        p_we_d    = 1'b0;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        d_we_d    = 1'b0;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CLEAR;
                    clr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            CLEAR: begin
                // each port stops once its own memory is exhausted
                if (clr_q < P_CLR) begin
                    p_we_d    = 1'b1;
                    p_addr_d  = clr_q[PA-1:0];
                    p_wdata_d = PROG_FILL;
                end
                if (clr_q < D_CLR) begin
                    d_we_d    = 1'b1;
                    d_addr_d  = clr_q[DA-1:0];
                    d_wdata_d = DATA_FILL;
                end
                if (clr_q == CLR_LAST) begin
                    state_d = HEADER;
                end else begin
                    clr_d = clr_q + 32'd1;
                end
            end
            HEADER: begin
                if (accept) begin
                    tgt_d = hdr_tgt;
                    ptr_d = {1'b0, hdr_base};
                    rem_d = hdr_cnt;
                    if (in_last) begin
                        state_d = RELEASE;
                    end else if (hdr_cnt != '0) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (!tgt_q) begin
                        if (ptr_q < P_LIM) begin
                            p_we_d    = 1'b1;
                            p_addr_d  = ptr_q[PA-1:0];
                            p_wdata_d = in_data;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (ptr_q < D_LIM) begin
                            d_we_d    = 1'b1;
                            d_addr_d  = ptr_q[DA-1:0];
                            d_wdata_d = in_data;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ptr_d = ptr_q + 17'd1;
                    rem_d = rem_q - 15'd1;
                    if (in_last) begin
                        state_d = RELEASE;
                    end else if (rem_q == 15'd1) begin
                        state_d = HEADER;
                    end
                end
            end
            RELEASE: begin
                if (rel_q == REL_LAST) begin
                    state_d = DONE;
                end else begin
                    rel_d = rel_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // registered so the core sees a glitch-free reset line
        crst_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clr_q     <= '0;
            rel_q     <= '0;
            tgt_q     <= 1'b0;
            ptr_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            crst_q    <= 1'b0;
            p_we_q    <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            rel_q     <= rel_d;
            tgt_q     <= tgt_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            crst_q    <= crst_d;
            p_we_q    <= p_we_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            d_we_q    <= d_we_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
        end
    end

    assign in_ready   = rdy;
    assign prog_we    = p_we_q;
    assign prog_addr  = p_addr_q;
    assign prog_wdata = p_wdata_q;
    assign data_we    = d_we_q;
    assign data_addr  = d_addr_q;
    assign data_wdata = d_wdata_q;
    assign core_reset = crst_q;
    assign busy       = (state_q == CLEAR) || (state_q == HEADER) ||
                        (state_q == PAYLOAD) || (state_q == RELEASE);
    assign done       = (state_q == DONE);
    assign error      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader with a write scoreboard.
// Expected writes are queued by the stimulus; a negedge monitor pops them.
module tb_boot_loader;

    localparam logic [31:0] PFILL = 32'h0000_0013;
    localparam logic [31:0] DFILL = 32'hA5A5_A5A5;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic        data_we;
    logic [5:0]  data_addr;
    logic [31:0] data_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    boot_loader #(
        .WORD_WIDTH    (32),
        .PROG_DEPTH    (64),
        .DATA_DEPTH    (64),
        .PROG_FILL     (PFILL),
        .DATA_FILL     (DFILL),
        .RELEASE_DELAY (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t pq[$];
    ent_t dq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        ent_t e;
        if (prog_we === 1'b1) begin
            if (pq.size() == 0) begin
                chk("prog_unexpected_we", {58'd0, prog_addr}, 64'hFFFF);
            end else begin
                e = pq.pop_front();
                chk("prog_addr", {58'd0, prog_addr}, {58'd0, e.a});
                chk("prog_wdata", {32'd0, prog_wdata}, {32'd0, e.d});
            end
        end
        if (data_we === 1'b1) begin
            if (dq.size() == 0) begin
                chk("data_unexpected_we", {58'd0, data_addr}, 64'hFFFF);
            end else begin
                e = dq.pop_front();
                chk("data_addr", {58'd0, data_addr}, {58'd0, e.a});
                chk("data_wdata", {32'd0, data_wdata}, {32'd0, e.d});
            end
        end
    end

    task automatic push_p(input logic [5:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        pq.push_back(e);
    endtask

    task automatic push_d(input logic [5:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        dq.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < 64; i++) begin
            push_p(6'(i), PFILL);
            push_d(6'(i), DFILL);
        end
    endtask

    // called at a negedge; returns at a negedge
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_start(output int n);
        push_clear();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_core_reset", {63'd0, core_reset}, 64'd0);
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_error_clr", {63'd0, error}, 64'd0);
        wait_ready(n);
    endtask

    task automatic send(input logic [31:0] d, input logic l,
                        input int gaps, input logic exp_wr);
        int n;
        repeat (gaps) @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("write_latency", {63'd0, prog_we | data_we}, {63'd0, exp_wr});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("done", {63'd0, done}, 64'd1);
        chk("done_core_reset", {63'd0, core_reset}, 64'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_core_reset", {63'd0, core_reset}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_we", {62'd0, prog_we, data_we}, 64'd0);
        chk("rst_addr", {52'd0, prog_addr, data_addr}, 64'd0);
        chk("rst_wdata", {prog_wdata, data_wdata}, 64'd0);
        chk("rst_status", {61'd0, busy, done, error}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] v;
        reset    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals();

        // reset release with start held high: load begins next edge
        push_clear();
        reset = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("clr_busy", {63'd0, busy}, 64'd1);
        chk("clr_core_reset", {63'd0, core_reset}, 64'd0);
        wait_ready(n);
        chk("clr_len", 64'(n), 64'd64);

        // program image, 3 words
        send(32'h0003_0000, 1'b0, 0, 1'b0);
        push_p(6'd0, 32'h1111_0001);
        send(32'h1111_0001, 1'b0, 0, 1'b1);
        push_p(6'd1, 32'h2222_0002);
        send(32'h2222_0002, 1'b0, 0, 1'b1);
        push_p(6'd2, 32'h3333_0003);
        send(32'h3333_0003, 1'b1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("release_hold", {62'd0, core_reset, busy}, 64'd1);
            @(negedge clock);
        end
        chk("release_core_reset", {63'd0, core_reset}, 64'd1);
        chk("release_done", {62'd0, done, busy}, 64'd2);
        chk("release_error", {63'd0, error}, 64'd0);
        chk("q_empty_1", 64'(pq.size() + dq.size()), 64'd0);

        // restart from DONE, two data records
        do_start(n);
        chk("clr_len_2", 64'(n), 64'd64);
        send(32'h8001_001C, 1'b0, 0, 1'b0);
        push_d(6'h1C, 32'h5318_0008);
        send(32'h5318_0008, 1'b0, 0, 1'b1);
        send(32'h8001_0030, 1'b0, 0, 1'b0);
        push_d(6'h30, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 1'b1, 0, 1'b1);
        wait_done();
        chk("data_error", {63'd0, error}, 64'd0);
        chk("q_empty_2", 64'(pq.size() + dq.size()), 64'd0);

        // zero-count header, then overrun at the top of data memory
        do_start(n);
        send(32'h0000_0005, 1'b0, 0, 1'b0);
        chk("cnt0_in_header", {63'd0, in_ready}, 64'd1);
        send(32'h8002_003F, 1'b0, 0, 1'b0);
        push_d(6'h3F, 32'h0A0A_0A0A);
        send(32'h0A0A_0A0A, 1'b0, 0, 1'b1);
        send(32'h0B0B_0B0B, 1'b1, 0, 1'b0);
        wait_done();
        chk("overrun_error", {63'd0, error}, 64'd1);
        chk("q_empty_3", 64'(pq.size() + dq.size()), 64'd0);

        // backpressure: random idle gaps between beats
        do_start(n);
        send(32'h0006_000A, 1'b0, $urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 6; i++) begin
            v = 32'hC0DE_0000 + 32'(i);
            push_p(6'(10 + i), v);
            send(v, (i == 5), $urandom_range(0, 3), 1'b1);
        end
        wait_done();
        chk("bp_error", {63'd0, error}, 64'd0);
        chk("q_empty_4", 64'(pq.size() + dq.size()), 64'd0);

        // abort mid-payload with reset
        do_start(n);
        send(32'h0001_0040, 1'b0, 0, 1'b0);
        send(32'h0000_1234, 1'b0, 0, 1'b0);
        chk("prog_overrun_error", {63'd0, error}, 64'd1);
        send(32'h0004_0000, 1'b0, 0, 1'b0);
        push_p(6'd0, 32'h0000_0077);
        send(32'h0000_0077, 1'b0, 0, 1'b1);
        push_p(6'd1, 32'h0000_0088);
        send(32'h0000_0088, 1'b0, 0, 1'b1);
        @(negedge clock);
        chk("pre_abort_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clock);
        chk("rst_start_ignored", {63'd0, busy}, 64'd0);
        chk("q_empty_5", 64'(pq.size() + dq.size()), 64'd0);
        push_clear();
        reset = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("abort_restart", {61'd0, busy, core_reset, error}, 64'd4);
        wait_ready(n);
        chk("clr_len_5", 64'(n), 64'd64);
        send(32'h0000_0000, 1'b1, 0, 1'b0);
        wait_done();
        chk("q_empty_6", 64'(pq.size() + dq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
